mem_bank_ram: RTL

- Parametrised single-port synchronous RAM with byte-lane write enables, a read-valid strobe and a hardware clear sequencer.
- Successor to the fixed 64x8 memory in the datapath; used for register files, scratch data and program buffers.
- After reset, or on request, the clear sequencer fills every word with INIT_VAL, one word per cycle, so no simulation-only initial block is needed.

---
 rtl/mem_bank_ram.sv | 110 +++++++++++
 1 files changed

// File: rtl/mem_bank_ram.sv
// Single-port synchronous RAM with byte-lane writes, a read-valid strobe and a hardware clear sweep.
// Optional macro MEM_BANK_OUT_REG_EN adds an output register, so read/write-through latency becomes 2.
//
// state | meaning
// CLEAR | sweep writes INIT_VAL to mem[cnt], one word per cycle; accesses ignored
// IDLE  | accesses serviced; clr starts a new sweep
module mem_bank_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH = 64,
  parameter logic [DATA_W-1:0] INIT_VAL = '1
) (
  input  logic                  clk,
  input  logic                  Rst,
  input  logic                  En,
  input  logic                  wea,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  input  logic                  clr,
  output logic [DATA_W-1:0]     dout,
  output logic                  rd_valid,
  output logic                  busy
);

  localparam int LANES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic access, in_range, sweep_we, wr_en;
  logic [DATA_W-1:0] old_word, merged, resp;

  always_ff @(posedge clk) begin
    if (Rst) state_q <= CLEAR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (cnt == LAST) state_d = IDLE;
      IDLE:    if (clr) state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    busy     = (state_q == CLEAR);
    sweep_we = (state_q == CLEAR) && !Rst;
    access   = (state_q == IDLE) && En && !Rst;
    wr_en    = access && wea && in_range;
  end

  always_ff @(posedge clk) begin
    if (Rst)                    cnt <= '0;
    else if (state_q == CLEAR)  cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    else                        cnt <= '0;
  end

  // Out-of-range addresses never touch the array and read back as INIT_VAL.
  assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
  assign old_word = in_range ? mem[addr] : INIT_VAL;

  always_comb begin
    merged = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (wea && be[i]) merged[8*i +: 8] = din[8*i +: 8];
    end
    resp = in_range ? merged : INIT_VAL;
  end

  always_ff @(posedge clk) begin
    if (sweep_we)   mem[cnt] <= INIT_VAL;
    else if (wr_en) mem[addr] <= merged;
  end

`ifdef MEM_BANK_OUT_REG_EN
  logic [DATA_W-1:0] stage_data;
  logic stage_valid;

  always_ff @(posedge clk) begin
    if (Rst) begin
      stage_data  <= '0;
      stage_valid <= 1'b0;
      dout        <= '0;
      rd_valid    <= 1'b0;
    end else begin
      stage_valid <= access;
      if (access) stage_data <= resp;
      rd_valid <= stage_valid;
      if (stage_valid) dout <= stage_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (Rst) begin
      dout     <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= access;
      if (access) dout <= resp;
    end
  end
`endif

endmodule
